// File: rtl/pipe_frame_ctrl.sv
// Frame controller wrapped around a streaming pipeline core: resets the core,
// gates a fixed number of tokens in and out per frame, and aborts on a stall.
module pipe_frame_ctrl #(
    parameter int DATA_W     = 64,
    parameter int IN_TOKENS  = 76800,
    parameter int OUT_TOKENS = 76800,
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 1048576
) (
    input  logic                              clk,
    input  logic                              rst_n,

    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              error,

    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_W-1:0]                 in_data,

    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_W-1:0]                 out_data,

    output logic                              pipe_reset,
    output logic                              pipe_in_valid,
    input  logic                              pipe_in_ready,
    output logic [DATA_W-1:0]                 pipe_in_data,
    input  logic                              pipe_out_valid,
    output logic                              pipe_out_ready,
    input  logic [DATA_W-1:0]                 pipe_out_data,

    output logic [$clog2(IN_TOKENS+1)-1:0]    in_count,
    output logic [$clog2(OUT_TOKENS+1)-1:0]   out_count,
    output logic [1:0]                        o_dbg_state
);

    localparam int IW = $clog2(IN_TOKENS + 1);
    localparam int OW = $clog2(OUT_TOKENS + 1);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [IW-1:0] IN_MAX   = IW'(IN_TOKENS);
    localparam logic [OW-1:0] OUT_MAX  = OW'(OUT_TOKENS);
    localparam logic [OW-1:0] OUT_LAST = OW'(OUT_TOKENS - 1);
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RESET = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_in_cnt;
    logic [OW-1:0]   r_out_cnt;
    logic [RW-1:0]   r_rst_cnt;
    logic [TW-1:0]   r_to_cnt;
    logic            r_busy;
    logic            r_done;
    logic            r_error;
    logic            r_pipe_reset;

    logic            w_in_open;
    logic            w_out_open;
    logic            w_in_hs;
    logic            w_out_hs;

    // Handshakes are valid/ready: a token moves on a cycle where both are high;
    // the gates only pass valid/ready while the frame still wants tokens and
    // are forced closed while rst_n is low.
    assign w_in_open  = rst_n && (r_state == S_RUN) && (r_in_cnt < IN_MAX);
    assign w_out_open = rst_n && (r_state == S_RUN) && (r_out_cnt < OUT_MAX);

    assign pipe_in_valid  = in_valid && w_in_open;
    assign in_ready       = pipe_in_ready && w_in_open;
    assign pipe_in_data   = in_data;

    assign out_valid      = pipe_out_valid && w_out_open;
    assign pipe_out_ready = out_ready && w_out_open;
    assign out_data       = pipe_out_data;

    assign w_in_hs  = in_valid && in_ready;
    assign w_out_hs = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_in_cnt     <= '0;
            r_out_cnt    <= '0;
            r_rst_cnt    <= '0;
            r_to_cnt     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_pipe_reset <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_RESET;
                        r_in_cnt  <= '0;
                        r_out_cnt <= '0;
                        r_rst_cnt <= '0;
                        r_to_cnt  <= '0;
                        r_error   <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                S_RESET: begin
                    if (r_rst_cnt == RST_LAST) begin
                        r_state      <= S_RUN;
                        r_pipe_reset <= 1'b0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + RW'(1);
                    end
                end
                S_RUN: begin
                    if (w_in_hs) begin
                        r_in_cnt <= r_in_cnt + IW'(1);
                    end
                    // A handshake on the expiry cycle wins over the timeout.
                    if (w_out_hs) begin
                        r_out_cnt <= r_out_cnt + OW'(1);
                        r_to_cnt  <= '0;
                        if (r_out_cnt == OUT_LAST) begin
                            r_state      <= S_DONE;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                            r_pipe_reset <= 1'b1;
                        end
                    end else if (r_to_cnt == TO_LAST) begin
                        r_state      <= S_IDLE;
                        r_error      <= 1'b1;
                        r_busy       <= 1'b0;
                        r_pipe_reset <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign pipe_reset  = r_pipe_reset;
    assign in_count    = r_in_cnt;
    assign out_count   = r_out_cnt;
    assign o_dbg_state = r_state;

endmodule

// File: doc/pipe_frame_ctrl.md
PIPE_FRAME_CTRL -- requirements
Module: pipe_frame_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 64, payload width on all data ports.
REQ-002 SHALL have parameter IN_TOKENS, default 76800, input tokens accepted per frame (>=1).
REQ-003 SHALL have parameter OUT_TOKENS, default 76800, output tokens emitted per frame (>=1).
REQ-004 SHALL have parameter RST_CYCLES, default 4, cycles pipe_reset is held after start (>=1).
REQ-005 SHALL have parameter TIMEOUT, default 1048576, max cycles in RUN without an output handshake (>=2).
REQ-006 SHALL have ports: clk in 1 clock; rst_n in 1 reset, synchronous, active-low; one clock domain only.
REQ-007 SHALL have ports: start in 1 frame-start pulse; busy out 1 frame in progress; done out 1 one-cycle frame-complete pulse; error out 1 sticky timeout flag.
REQ-008 SHALL have upstream ports: in_valid in 1; in_ready out 1; in_data in DATA_W.
REQ-009 SHALL have downstream ports: out_valid out 1; out_ready in 1; out_data out DATA_W.
REQ-010 SHALL have pipeline-side ports: pipe_reset out 1 (active-high sync reset to core); pipe_in_valid out 1; pipe_in_ready in 1; pipe_in_data out DATA_W; pipe_out_valid in 1; pipe_out_ready out 1; pipe_out_data in DATA_W.
REQ-011 SHALL have status ports in_count out $clog2(IN_TOKENS+1) and out_count out $clog2(OUT_TOKENS+1), the current-frame handshake counts.

Function
REQ-012 SHALL implement FSM states IDLE, RESET, RUN, DONE.
REQ-013 IDLE: pipe_reset=1, busy=0; start=1 -> RESET, clears in_count, out_count, reset-cycle counter and timeout counter, and clears error.
REQ-014 RESET: pipe_reset=1, busy=1; after exactly RST_CYCLES cycles in RESET -> RUN.
REQ-015 RUN: pipe_reset=0, busy=1; on the cycle out_count reaches OUT_TOKENS -> DONE.
REQ-016 DONE: lasts exactly one cycle, done=1, busy=0, pipe_reset=1; -> IDLE.
REQ-017 start SHALL be ignored in RESET, RUN and DONE.
REQ-018 Input gate: in_open = (state==RUN) && (in_count<IN_TOKENS); pipe_in_valid=in_valid&&in_open; in_ready=pipe_in_ready&&in_open; pipe_in_data=in_data, combinational, zero latency.
REQ-019 Output gate: out_open = (state==RUN) && (out_count<OUT_TOKENS); out_valid=pipe_out_valid&&out_open; pipe_out_ready=out_ready&&out_open; out_data=pipe_out_data, combinational.
REQ-020 in_count SHALL increment on each in_valid&&in_ready cycle and saturate at IN_TOKENS; excess upstream tokens stall with in_ready=0.
REQ-021 out_count SHALL increment on each out_valid&&out_ready cycle; it never exceeds OUT_TOKENS.
REQ-022 Timeout counter SHALL count RUN cycles since the last output handshake and reset to 0 on each handshake.
REQ-023 When the timeout counter reaches TIMEOUT: error=1 (sticky until next accepted start), FSM -> IDLE directly, done NOT pulsed.
REQ-024 If a handshake and timeout expiry coincide in one cycle, the handshake SHALL win (counter cleared, no error).
REQ-025 If the final output handshake occurs while input tokens remain unsent, FSM SHALL still enter DONE; remaining input is not consumed.
REQ-026 All status outputs (busy, done, error, counts) SHALL be registered; gates are combinational from registered state.

Reset
REQ-027 rst_n=0 at a rising clk edge SHALL force IDLE, counters=0, error=0, done=0, busy=0, pipe_reset=1, from any state including mid-frame.
REQ-028 During rst_n=0, in_ready, out_valid, pipe_in_valid, pipe_out_ready SHALL be 0.

Verification
REQ-029 Basic frame: IN=OUT=8, RST_CYCLES=4; start pulse -> pipe_reset high 4 cycles after start, 8 tokens each way, done pulses one cycle after 8th output handshake, busy low thereafter.
REQ-030 Backpressure: random out_ready/pipe_in_ready at 50% -> data order preserved, counts exact, no token lost or duplicated.
REQ-031 Overflow input: 12 tokens offered with IN_TOKENS=8 -> exactly 8 accepted, in_ready=0 with in_count=8, tokens 9-12 remain pending.
REQ-032 Timeout: TIMEOUT=16, pipe_out_valid held 0 in RUN -> error=1 on 16th cycle, FSM IDLE, done never asserted; next start clears error.
REQ-033 Reset mid-frame: rst_n=0 one cycle with in_count=3 -> IDLE, counts 0, pipe_reset=1; start ignored during RUN (no count clear).
REQ-034 Coincidence: output handshake on exact timeout cycle -> error stays 0, frame continues.
